// File: rtl/command_definition_pkg.sv
// Shared DDR3 command encodings, issue-queue entry format and the
// generator FSM state type used by bank_command_generator.
package command_definition_pkg;

   localparam int CMD_NUM_BANKS = 8;
   localparam int CMD_BANK_W    = 3;
   localparam int CMD_ROW_W     = 14;
   localparam int CMD_COL_W     = 10;

   typedef enum logic [3:0] {
      NOP  = 4'd0,
      ACT  = 4'd1,
      RD   = 4'd2,
      WR   = 4'd3,
      RDA  = 4'd4,
      WRA  = 4'd5,
      PRE  = 4'd6,
      PREA = 4'd7,
      REF  = 4'd8
   } command_t;

   typedef struct packed {
      command_t                command;
      logic [CMD_BANK_W-1:0]   bank_addr;
      logic [CMD_ROW_W-1:0]    row_addr;
      logic [CMD_COL_W-1:0]    col_addr;
   } bank_command_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_ACT  = 3'd2,
      ST_RW   = 3'd3,
      ST_PREA = 3'd4,
      ST_REF  = 3'd5
   } gen_state_t;

   // Build one issue-queue entry from its fields.
   function automatic bank_command_t make_cmd(input command_t              op,
                                              input logic [CMD_BANK_W-1:0] bank,
                                              input logic [CMD_ROW_W-1:0]  row,
                                              input logic [CMD_COL_W-1:0]  col);
      bank_command_t c;
      c.command   = op;
      c.bank_addr = bank;
      c.row_addr  = row;
      c.col_addr  = col;
      return c;
   endfunction

endpackage

// File: rtl/open_row_table.sv
// Per-bank open-row tracker: {valid, row} for each bank, combinational
// lookup, single-bank set/clear and a clear-all used before refresh.
module open_row_table #(
   parameter int NUM_BANKS = 8,
   parameter int BANK_BITS = 3,
   parameter int ROW_BITS  = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BANK_BITS-1:0] lookup_bank_i,
   output logic                 lookup_valid_o,
   output logic [ROW_BITS-1:0]  lookup_row_o,
   output logic                 any_open_o,
   input  logic                 set_i,
   input  logic [BANK_BITS-1:0] set_bank_i,
   input  logic [ROW_BITS-1:0]  set_row_i,
   input  logic                 clear_i,
   input  logic [BANK_BITS-1:0] clear_bank_i,
   input  logic                 clear_all_i
);

   logic [NUM_BANKS-1:0] valid_q;
   logic [ROW_BITS-1:0]  row_q [NUM_BANKS];

   assign lookup_valid_o = valid_q[lookup_bank_i];
   assign lookup_row_o   = row_q[lookup_bank_i];
   assign any_open_o     = |valid_q;

   // Table storage; clear_all dominates, then single-bank clear, then set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
      end else if (clear_all_i) begin
         valid_q <= '0;
      end else if (clear_i) begin
         valid_q[clear_bank_i] <= 1'b0;
      end else if (set_i) begin
         valid_q[set_bank_i] <= 1'b1;
         row_q[set_bank_i]   <= set_row_i;
      end
   end

endmodule

// File: rtl/bank_command_generator.sv
// Turns front-end read/write requests and refresh requests into DDR3
// command entries for the issue queue. Open-page policy by default;
// define AUTO_PRECHARGE_EN for close-page (RDA/WRA, no PRE/PREA).
// The output register always holds the command belonging to the current
// state; the next command is loaded on the edge the queue accepts it.
module bank_command_generator
   import command_definition_pkg::*;
#(
   parameter int NUM_BANKS = CMD_NUM_BANKS,
   parameter int BANK_BITS = CMD_BANK_W,
   parameter int ROW_BITS  = CMD_ROW_W,
   parameter int COL_BITS  = CMD_COL_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init_done_flag,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [BANK_BITS-1:0] req_bank,
   input  logic [ROW_BITS-1:0]  req_row,
   input  logic [COL_BITS-1:0]  req_col,
   input  logic                 refresh_req,
   output logic                 refresh_ack,
   input  logic                 issue_queue_full,
   output logic                 issue_queue_wen,
   output bank_command_t        issue_queue_cmd
);

   gen_state_t           state_q, state_d;
   logic                 wen_q, wen_d;
   bank_command_t        cmd_q, cmd_d;
   logic                 write_q;
   logic [BANK_BITS-1:0] bank_q;
   logic [ROW_BITS-1:0]  row_q;
   logic [COL_BITS-1:0]  col_q;

   logic                 latch_req;
   logic                 accept;
   logic                 lk_valid;
   logic [ROW_BITS-1:0]  lk_row;
   logic                 any_open;
   logic                 tbl_set, tbl_clear, tbl_clear_all;

   function automatic command_t rw_op(input logic wr);
`ifdef AUTO_PRECHARGE_EN
      return wr ? WRA : RDA;
`else
      return wr ? WR : RD;
`endif
   endfunction

   assign accept          = wen_q && !issue_queue_full;
   assign req_ready       = (state_q == ST_IDLE) && init_done_flag && !refresh_req;
   assign refresh_ack     = (state_q == ST_REF) && accept;
   assign issue_queue_wen = wen_q;
   assign issue_queue_cmd = cmd_q;

   open_row_table #(
      .NUM_BANKS (NUM_BANKS),
      .BANK_BITS (BANK_BITS),
      .ROW_BITS  (ROW_BITS)
   ) u_table (
      .clk            (clk),
      .rst            (rst),
      .lookup_bank_i  (req_bank),
      .lookup_valid_o (lk_valid),
      .lookup_row_o   (lk_row),
      .any_open_o     (any_open),
      .set_i          (tbl_set),
      .set_bank_i     (bank_q),
      .set_row_i      (row_q),
      .clear_i        (tbl_clear),
      .clear_bank_i   (bank_q),
      .clear_all_i    (tbl_clear_all)
   );

   // Next-state, next output entry and table update strobes.
   always_comb begin
      state_d       = state_q;
      wen_d         = wen_q;
      cmd_d         = cmd_q;
      latch_req     = 1'b0;
      tbl_set       = 1'b0;
      tbl_clear     = 1'b0;
      tbl_clear_all = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (refresh_req && init_done_flag) begin
               wen_d = 1'b1;
`ifdef AUTO_PRECHARGE_EN
               state_d = ST_REF;
               cmd_d   = make_cmd(REF, '0, '0, '0);
`else
               if (any_open) begin
                  state_d = ST_PREA;
                  cmd_d   = make_cmd(PREA, '0, '0, '0);
               end else begin
                  state_d = ST_REF;
                  cmd_d   = make_cmd(REF, '0, '0, '0);
               end
`endif
            end else if (req_valid && req_ready) begin
               latch_req = 1'b1;
               wen_d     = 1'b1;
`ifdef AUTO_PRECHARGE_EN
               state_d = ST_ACT;
               cmd_d   = make_cmd(ACT, req_bank, req_row, '0);
`else
               if (lk_valid && (lk_row == req_row)) begin
                  state_d = ST_RW;
                  cmd_d   = make_cmd(rw_op(req_write), req_bank, req_row, req_col);
               end else if (lk_valid) begin
                  state_d = ST_PRE;
                  cmd_d   = make_cmd(PRE, req_bank, '0, '0);
               end else begin
                  state_d = ST_ACT;
                  cmd_d   = make_cmd(ACT, req_bank, req_row, '0);
               end
`endif
            end
         end
         ST_PRE: begin
            if (accept) begin
               tbl_clear = 1'b1;
               state_d   = ST_ACT;
               cmd_d     = make_cmd(ACT, bank_q, row_q, '0);
            end
         end
         ST_ACT: begin
            if (accept) begin
`ifndef AUTO_PRECHARGE_EN
               tbl_set = 1'b1;
`endif
               state_d = ST_RW;
               cmd_d   = make_cmd(rw_op(write_q), bank_q, row_q, col_q);
            end
         end
         ST_RW: begin
            if (accept) begin
               state_d = ST_IDLE;
               wen_d   = 1'b0;
               cmd_d   = make_cmd(NOP, '0, '0, '0);
            end
         end
         ST_PREA: begin
            if (accept) begin
               tbl_clear_all = 1'b1;
               state_d       = ST_REF;
               cmd_d         = make_cmd(REF, '0, '0, '0);
            end
         end
         ST_REF: begin
            if (accept) begin
               state_d = ST_IDLE;
               wen_d   = 1'b0;
               cmd_d   = make_cmd(NOP, '0, '0, '0);
            end
         end
         default: begin
            state_d = ST_IDLE;
            wen_d   = 1'b0;
            cmd_d   = make_cmd(NOP, '0, '0, '0);
         end
      endcase
   end

   // State and output entry register; reset drops wen immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wen_q   <= 1'b0;
         cmd_q   <= make_cmd(NOP, '0, '0, '0);
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         cmd_q   <= cmd_d;
      end
   end

   // Request latch, captured on the request handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_q <= 1'b0;
         bank_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else if (latch_req) begin
         write_q <= req_write;
         bank_q  <= req_bank;
         row_q   <= req_row;
         col_q   <= req_col;
      end
   end

endmodule

// File: tb/tb_bank_command_generator.sv
// Directed bench for bank_command_generator (open-page build).
module tb_bank_command_generator;
   import command_definition_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_done_flag;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [2:0]    req_bank;
   logic [13:0]   req_row;
   logic [9:0]    req_col;
   logic          refresh_req;
   logic          refresh_ack;
   logic          issue_queue_full;
   logic          issue_queue_wen;
   bank_command_t issue_queue_cmd;
   logic [30:0]   cmd_bits;

   int checks = 0;
   int fails  = 0;

   assign cmd_bits = issue_queue_cmd;

   always #5 clk = ~clk;

   bank_command_generator dut (
      .clk              (clk),
      .rst              (rst),
      .init_done_flag   (init_done_flag),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_bank         (req_bank),
      .req_row          (req_row),
      .req_col          (req_col),
      .refresh_req      (refresh_req),
      .refresh_ack      (refresh_ack),
      .issue_queue_full (issue_queue_full),
      .issue_queue_wen  (issue_queue_wen),
      .issue_queue_cmd  (issue_queue_cmd)
   );

   // Command codes: NOP 0, ACT 1, RD 2, WR 3, RDA 4, WRA 5, PRE 6, PREA 7, REF 8
   function automatic logic [30:0] ec(input logic [3:0] op, input logic [2:0] b,
                                      input logic [13:0] r, input logic [9:0] c);
      return {op, b, r, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic wr, input logic [2:0] b,
                            input logic [13:0] r, input logic [9:0] c);
      req_valid = 1'b1;
      req_write = wr;
      req_bank  = b;
      req_row   = r;
      req_col   = c;
   endtask

   task automatic test_reset();
      rst = 1'b1; init_done_flag = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_bank = '0; req_row = '0; req_col = '0; refresh_req = 1'b0; issue_queue_full = 1'b0;
      tick(); tick();
      if (issue_queue_wen !== 1'b0 || cmd_bits !== 31'd0 || req_ready !== 1'b0 || refresh_ack !== 1'b0) begin
         $display("FAIL reset: wen=%b cmd=%h ready=%b ack=%b required 0/0/0/0",
                  issue_queue_wen, cmd_bits, req_ready, refresh_ack);
         fails++;
      end
      checks++;
      rst = 1'b0;
   endtask

   task automatic test_init_gate();
      drive_req(1'b0, 3'd1, 14'h1, 10'h1);
      #1;
      if (req_ready !== 1'b0) begin
         $display("FAIL init_gate_ready: got %b required 0", req_ready); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b0) begin
         $display("FAIL init_gate_wen: got %b required 0", issue_queue_wen); fails++;
      end
      checks++;
      req_valid = 1'b0;
      init_done_flag = 1'b1;
   endtask

   task automatic test_closed_read();
      drive_req(1'b0, 3'd2, 14'h10, 10'h8);
      #1;
      if (req_ready !== 1'b1) begin
         $display("FAIL closed_ready: got %b required 1", req_ready); fails++;
      end
      checks++;
      tick(); req_valid = 1'b0;
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd1, 3'd2, 14'h10, 10'h0)) begin
         $display("FAIL closed_act: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd1, 3'd2, 14'h10, 10'h0)); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd2, 3'd2, 14'h10, 10'h8)) begin
         $display("FAIL closed_rd: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd2, 3'd2, 14'h10, 10'h8)); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b0) begin
         $display("FAIL closed_end: wen=%b required 0", issue_queue_wen); fails++;
      end
      checks++;
   endtask

   task automatic test_hit_read();
      drive_req(1'b0, 3'd2, 14'h10, 10'h20);
      tick(); req_valid = 1'b0;
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd2, 3'd2, 14'h10, 10'h20)) begin
         $display("FAIL hit_rd: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd2, 3'd2, 14'h10, 10'h20)); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b0) begin
         $display("FAIL hit_single: wen=%b required 0", issue_queue_wen); fails++;
      end
      checks++;
   endtask

   task automatic test_conflict_write();
      drive_req(1'b1, 3'd2, 14'h33, 10'h5);
      tick(); req_valid = 1'b0;
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd6, 3'd2, 14'h0, 10'h0)) begin
         $display("FAIL conf_pre: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd6, 3'd2, 14'h0, 10'h0)); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd1, 3'd2, 14'h33, 10'h0)) begin
         $display("FAIL conf_act: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd1, 3'd2, 14'h33, 10'h0)); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd3, 3'd2, 14'h33, 10'h5)) begin
         $display("FAIL conf_wr: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd3, 3'd2, 14'h33, 10'h5)); fails++;
      end
      checks++;
      tick();
      // Table now holds row 0x33 for bank 2: a read there must be a direct hit.
      drive_req(1'b0, 3'd2, 14'h33, 10'h1);
      tick(); req_valid = 1'b0;
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd2, 3'd2, 14'h33, 10'h1)) begin
         $display("FAIL conf_table: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd2, 3'd2, 14'h33, 10'h1)); fails++;
      end
      checks++;
      tick();
   endtask

   task automatic test_queue_full();
      drive_req(1'b0, 3'd5, 14'h44, 10'h3);
      tick(); req_valid = 1'b0;
      issue_queue_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd1, 3'd5, 14'h44, 10'h0)) begin
            $display("FAIL full_hold%0d: wen=%b cmd=%h required 1 %h", i, issue_queue_wen, cmd_bits, ec(4'd1, 3'd5, 14'h44, 10'h0)); fails++;
         end
         checks++;
      end
      issue_queue_full = 1'b0;
      tick();
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd2, 3'd5, 14'h44, 10'h3)) begin
         $display("FAIL full_rd: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd2, 3'd5, 14'h44, 10'h3)); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b0) begin
         $display("FAIL full_nodup: wen=%b required 0", issue_queue_wen); fails++;
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      drive_req(1'b0, 3'd5, 14'h44, 10'h1);
      tick();
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd2, 3'd5, 14'h44, 10'h1) || req_ready !== 1'b0) begin
         $display("FAIL b2b_first: wen=%b cmd=%h ready=%b required 1 %h 0", issue_queue_wen, cmd_bits, req_ready, ec(4'd2, 3'd5, 14'h44, 10'h1)); fails++;
      end
      checks++;
      req_col = 10'h2;
      tick();
      if (issue_queue_wen !== 1'b0 || req_ready !== 1'b1) begin
         $display("FAIL b2b_idle: wen=%b ready=%b required 0 1", issue_queue_wen, req_ready); fails++;
      end
      checks++;
      tick(); req_valid = 1'b0;
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd2, 3'd5, 14'h44, 10'h2)) begin
         $display("FAIL b2b_second: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd2, 3'd5, 14'h44, 10'h2)); fails++;
      end
      checks++;
      tick();
   endtask

   task automatic test_refresh();
      refresh_req = 1'b1;
      drive_req(1'b0, 3'd2, 14'h33, 10'h7);
      #1;
      if (req_ready !== 1'b0) begin
         $display("FAIL ref_ready: got %b required 0", req_ready); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd7, 3'd0, 14'h0, 10'h0) || refresh_ack !== 1'b0) begin
         $display("FAIL ref_prea: wen=%b cmd=%h ack=%b required 1 %h 0", issue_queue_wen, cmd_bits, refresh_ack, ec(4'd7, 3'd0, 14'h0, 10'h0)); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd8, 3'd0, 14'h0, 10'h0) || refresh_ack !== 1'b1) begin
         $display("FAIL ref_ref: wen=%b cmd=%h ack=%b required 1 %h 1", issue_queue_wen, cmd_bits, refresh_ack, ec(4'd8, 3'd0, 14'h0, 10'h0)); fails++;
      end
      checks++;
      refresh_req = 1'b0;
      tick();
      if (issue_queue_wen !== 1'b0 || refresh_ack !== 1'b0 || req_ready !== 1'b1) begin
         $display("FAIL ref_done: wen=%b ack=%b ready=%b required 0 0 1", issue_queue_wen, refresh_ack, req_ready); fails++;
      end
      checks++;
      tick(); req_valid = 1'b0;
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd1, 3'd2, 14'h33, 10'h0)) begin
         $display("FAIL ref_act: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd1, 3'd2, 14'h33, 10'h0)); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd2, 3'd2, 14'h33, 10'h7)) begin
         $display("FAIL ref_rd: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd2, 3'd2, 14'h33, 10'h7)); fails++;
      end
      checks++;
      tick();
   endtask

   task automatic test_reset_mid_sequence();
      drive_req(1'b1, 3'd2, 14'h55, 10'h9);
      tick(); req_valid = 1'b0;
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd6, 3'd2, 14'h0, 10'h0)) begin
         $display("FAIL rstmid_pre: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd6, 3'd2, 14'h0, 10'h0)); fails++;
      end
      checks++;
      rst = 1'b1;
      #1;
      if (issue_queue_wen !== 1'b0) begin
         $display("FAIL rstmid_wen: wen=%b required 0", issue_queue_wen); fails++;
      end
      checks++;
      tick();
      rst = 1'b0;
      drive_req(1'b1, 3'd2, 14'h55, 10'h9);
      tick(); req_valid = 1'b0;
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd1, 3'd2, 14'h55, 10'h0)) begin
         $display("FAIL rstmid_act: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd1, 3'd2, 14'h55, 10'h0)); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b1 || cmd_bits !== ec(4'd3, 3'd2, 14'h55, 10'h9)) begin
         $display("FAIL rstmid_wr: wen=%b cmd=%h required 1 %h", issue_queue_wen, cmd_bits, ec(4'd3, 3'd2, 14'h55, 10'h9)); fails++;
      end
      checks++;
      tick();
      if (issue_queue_wen !== 1'b0) begin
         $display("FAIL rstmid_end: wen=%b required 0", issue_queue_wen); fails++;
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_init_gate();
      test_closed_read();
      test_hit_read();
      test_conflict_write();
      test_queue_full();
      test_back_to_back();
      test_refresh();
      test_reset_mid_sequence();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
